pc_block: RTL and testbench

- Program-counter register for the single-cycle RISC-V core.
- Captures the next-instruction address chosen by the next-PC mux every clock. Presents it as the current fetch address to instruction memory and the PC+4 adder.
- Provides a registered valid flag and a misalignment flag for downstream fetch/trap logic.

---
 rtl/pc_block.sv | 47 ++++
 tb/tb_pc_block.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pc_block.sv
// Program-counter register for the single-cycle RISC-V core, with a PC+4 output.
// Define PC_ALIGN_CHECK_EN to force word alignment and flag misaligned targets.
`timescale 1ns/1ps
module pc_block #(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] next_addr,
   output logic [XLEN-1:0] curr_addr,
   output logic [XLEN-1:0] pc_plus4,
   output logic            pc_valid,
   output logic            misaligned
);

   logic [XLEN-1:0] load_addr;

`ifdef PC_ALIGN_CHECK_EN
   assign load_addr = {next_addr[XLEN-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         misaligned <= 1'b0;
      end else begin
         misaligned <= (next_addr[1:0] != 2'b00);
      end
   end
`else
   assign load_addr  = next_addr;
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         curr_addr <= RESET_ADDR;
         pc_valid  <= 1'b0;
      end else begin
         curr_addr <= load_addr;
         pc_valid  <= 1'b1;
      end
   end

   // The carry out of the adder is dropped, so the top word wraps to zero.
   assign pc_plus4 = curr_addr + XLEN'(4);

endmodule

// File: tb/tb_pc_block.sv
// Directed self-checking bench for pc_block; follows PC_ALIGN_CHECK_EN when defined.
`timescale 1ns/1ps
module tb_pc_block;

   logic        clk;
   logic        rst;
   logic [31:0] next_addr;
   logic [31:0] curr_addr;
   logic [31:0] pc_plus4;
   logic        pc_valid;
   logic        misaligned;

   int checks = 0;
   int errors = 0;

   pc_block #(.XLEN(32), .RESET_ADDR(32'h0000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .next_addr  (next_addr),
      .curr_addr  (curr_addr),
      .pc_plus4   (pc_plus4),
      .pc_valid   (pc_valid),
      .misaligned (misaligned)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic at(input time t);
      if (t > $time) #(t - $time);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst       = 1'b1;
      next_addr = 32'h0000_0000;

      // Reset at the 50 ns edge.
      at(51);
      check("reset_curr",  curr_addr, 32'h0000_0000);
      check("reset_valid", {31'b0, pc_valid}, 32'd0);
      check("reset_mis",   {31'b0, misaligned}, 32'd0);
      check("reset_plus4", pc_plus4, 32'h0000_0004);

      at(60);
      rst       = 1'b0;
      next_addr = 32'h0000_1111;
      at(151);
      check("load_curr",  curr_addr, 32'h0000_1111);
      check("load_plus4", pc_plus4, 32'h0000_1115);
      check("load_valid", {31'b0, pc_valid}, 32'd1);

      // Reset raised between edges has no effect until the next edge.
      at(199);
      rst = 1'b1;
      at(200);
      check("rst_pending_curr",  curr_addr, 32'h0000_1111);
      check("rst_pending_valid", {31'b0, pc_valid}, 32'd1);
      at(251);
      check("rst_mid_curr",  curr_addr, 32'h0000_0000);
      check("rst_mid_valid", {31'b0, pc_valid}, 32'd0);

      at(299);
      rst       = 1'b0;
      next_addr = 32'h0000_4444;
      at(351);
      check("after_rst_curr",  curr_addr, 32'h0000_4444);
      check("after_rst_valid", {31'b0, pc_valid}, 32'd1);
      check("after_rst_mis",   {31'b0, misaligned}, 32'd0);
      at(451);
      check("hold_curr", curr_addr, 32'h0000_4444);

      // 60 ns reset pulse lying entirely between the 450 and 550 edges.
      at(460);
      rst       = 1'b1;
      next_addr = 32'h0000_5555;
      at(520);
      rst = 1'b0;
      at(551);
`ifdef PC_ALIGN_CHECK_EN
      check("glitch_curr", curr_addr, 32'h0000_5554);
      check("glitch_mis",  {31'b0, misaligned}, 32'd1);
`else
      check("glitch_curr", curr_addr, 32'h0000_5555);
      check("glitch_mis",  {31'b0, misaligned}, 32'd0);
`endif
      check("glitch_valid", {31'b0, pc_valid}, 32'd1);

      at(560);
      next_addr = 32'hFFFF_FFFC;
      at(651);
      check("wrap_curr",  curr_addr, 32'hFFFF_FFFC);
      check("wrap_plus4", pc_plus4, 32'h0000_0000);
      check("wrap_mis",   {31'b0, misaligned}, 32'd0);

      at(660);
      next_addr = 32'h0000_1002;
      at(751);
`ifdef PC_ALIGN_CHECK_EN
      check("align_curr",  curr_addr, 32'h0000_1000);
      check("align_plus4", pc_plus4, 32'h0000_1004);
      check("align_mis",   {31'b0, misaligned}, 32'd1);
`else
      check("align_curr",  curr_addr, 32'h0000_1002);
      check("align_plus4", pc_plus4, 32'h0000_1006);
      check("align_mis",   {31'b0, misaligned}, 32'd0);
`endif

      // Reset takes priority over a pending next_addr and clears the flags.
      at(760);
      rst       = 1'b1;
      next_addr = 32'h0000_8888;
      at(851);
      check("prio_curr",  curr_addr, 32'h0000_0000);
      check("prio_valid", {31'b0, pc_valid}, 32'd0);
      check("prio_mis",   {31'b0, misaligned}, 32'd0);

      at(860);
      rst = 1'b0;
      at(951);
      check("resume_curr",  curr_addr, 32'h0000_8888);
      check("resume_plus4", pc_plus4, 32'h0000_888C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
